cpu6_csrfile: RTL and testbench
===============================

Name: cpu6_csrfile

Overview:
- Machine-mode CSR register file for cpu6. Sits downstream of the main decoder.
- Consumes the decoder's csr, csr_rs1uimm and csr_wsc controls for the instruction in the execute stage, plus the decoder's illinstr flag (as exc_valid) and a retire strobe.
- Returns the old CSR value for rd writeback.
- Holds trap state (mepc/mcause/mtval/mstatus) and supplies the trap vector to fetch.

Parameters:
RESET_MTVEC, 32'h0000_0000, reset value of mtvec (trap base, direct mode only)
MISA_VALUE, 32'h4000_0100, read-only misa contents (RV32I)

Ports:
clk  in  1  clock
resetn  in  1  reset
csr_en  in  1  valid CSR instruction in EX (decoder csr, already qualified by stage valid)
csr_wsc  in  2  operation: CPU6_CSR_WSC_W / _S / _C encodings from defines.v
csr_rs1uimm  in  1  0: operand = rs1_data; 1: operand = zero-extended csr_rs1idx
csr_rs1idx  in  5  rs1 field (register index or uimm)
csr_addr  in  12  instr[31:20]
rs1_data  in  32  rs1 register value
csr_rdata  out  32  old CSR value, combinational
csr_illegal  out  1  access to unimplemented CSR, or write to read-only CSR, combinational
exc_valid  in  1  illegal-instruction trap taken this cycle
exc_pc  in  32  PC of faulting instruction
exc_instr  in  32  faulting instruction bits
mret  in  1  MRET committing this cycle
instr_retire  in  1  one instruction retired this cycle
trap_vec  out  32  {mtvec[31:2],2'b00}
epc  out  32  mepc, for MRET redirect
Reset is asynchronous, active-low (resetn); single clock clk.

Behaviour:
- Address map:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11; other bits read 0.
  - misa 0x301: reads MISA_VALUE; writes ignored, not illegal.
  - mtvec 0x305: bits[1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342, mtval 0x343.
  - mhartid 0xF14: reads 0.
  - Counters: see Optional Feature.
- Reset values: mstatus=32'h0000_1800, mtvec=RESET_MTVEC, all other state 0. csr_rdata/csr_illegal follow the reset state combinationally.
- Read: csr_rdata = current value of csr_addr while csr_en=1, else 0. Zero latency.
- Operand: csr_rs1uimm ? {27'b0,csr_rs1idx} : rs1_data.
- New value: W → operand; S → old|operand; C → old&~operand.
- Write enable: csr_en & ~csr_illegal & ~exc_valid & (wsc==W | csr_rs1idx!=0). S/C with index 0 never writes, and never flags illegal on read-only CSRs.
- Writes take effect at the next rising edge; a read in the following cycle returns the new value.
- csr_illegal=1 when csr_en and the address is unimplemented, or when csr_addr[11:10]==2'b11 and a write would occur. No state changes on an illegal access.
- Trap (exc_valid=1), at the edge:
  - mepc←exc_pc, mcause←32'd2, mtval←exc_instr.
  - MPIE←MIE, MIE←0.
  - Overrides any CSR write and any mret in the same cycle.
- mret (no exc_valid): MIE←MPIE, MPIE←1. A same-cycle explicit mstatus write loses to mret.
- Reset mid-operation: all state returns to reset values immediately; in-flight writes are dropped.

Optional Feature:
- Macro: CPU6_CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle (0xB00 low / 0xB80 high) increments every cycle.
  - 64-bit minstret (0xB02 / 0xB82) increments on instr_retire.
  - Carry propagates from the low into the high half; 2^64-1 wraps to 0.
  - An explicit write to a half replaces that half for that cycle. The increment is suppressed in that cycle for the whole counter.
- Not defined: the four addresses are unimplemented and raise csr_illegal. No counter flops exist.

Test Plan:
- Reset → read 0x300 = 0x0000_1800; 0x305 = RESET_MTVEC; csr_illegal=0.
- CSRRW 0x340, rs1_data=0xDEAD_BEEF → old 0 returned. Next cycle CSRRS 0x340, idx=0 → 0xDEAD_BEEF, no write. Then CSRRCI with uimm=0x0F → value 0xDEAD_BEE0.
- csr_en, csr_addr=0x7C0 → csr_illegal=1, csr_rdata=0. CSRRW 0xF14 → illegal, no write. CSRRS 0xF14 with idx=0 → legal, read 0.
- MIE set via CSRRSI 0x300 uimm=8, then exc_valid with exc_pc=0x100, exc_instr=0xFFFF_FFFF and a same-cycle CSRRW mscratch → mepc=0x100, mcause=2, mtval=0xFFFF_FFFF, mstatus=0x1880, mscratch unchanged. Then mret → mstatus=0x1888, epc=0x100.
- With CPU6_CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0 → two cycles later mcycleh=1, mcycle=0x0000_0000 (wrap/carry). minstret counts only pulsed instr_retire cycles.
- Assert resetn low mid-write of mtvec=0x200 → mtvec=RESET_MTVEC after release.

Source files
------------

// File: rtl/cpu6_csrfile.sv
// cpu6_csrfile: machine-mode CSR file with trap/mret state and trap vector.
// Optional 64-bit mcycle/minstret counters when CPU6_CSR_COUNTERS_EN is defined.
module cpu6_csrfile #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_en,
  input  logic [1:0]  csr_wsc,
  input  logic        csr_rs1uimm,
  input  logic [4:0]  csr_rs1idx,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_instr,
  input  logic        mret,
  input  logic        instr_retire,
  output logic [31:0] trap_vec,
  output logic [31:0] epc
);
  localparam logic [1:0] CSR_WSC_W = 2'b01;
  localparam logic [1:0] CSR_WSC_S = 2'b10;
  localparam logic [1:0] CSR_WSC_C = 2'b11;
  logic        mie, mpie;
  logic [29:0] mtvec_q, mepc_q;
  logic [31:0] mscratch, mcause, mtval;
  logic        impl, wr_req, we;
  logic [31:0] old_val, operand, new_val;
`ifdef CPU6_CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif
  assign operand = csr_rs1uimm ? {27'b0, csr_rs1idx} : rs1_data;
  assign new_val = csr_wsc == CSR_WSC_S ? old_val | operand :
                   csr_wsc == CSR_WSC_C ? old_val & ~operand : operand;
  assign wr_req = csr_en & (csr_wsc == CSR_WSC_W | csr_rs1idx != 5'd0);
  assign csr_illegal = csr_en & (~impl | (csr_addr[11:10] == 2'b11 & wr_req));
  assign we = wr_req & ~csr_illegal & ~exc_valid;
  assign csr_rdata = csr_en ? old_val : 32'b0;
  assign trap_vec = {mtvec_q, 2'b00};
  assign epc = {mepc_q, 2'b00};
  always_comb begin
    impl = 1'b1;
    old_val = 32'b0;
    case (csr_addr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      12'h301: old_val = MISA_VALUE;
      12'h305: old_val = {mtvec_q, 2'b00};
      12'h340: old_val = mscratch;
      12'h341: old_val = {mepc_q, 2'b00};
      12'h342: old_val = mcause;
      12'h343: old_val = mtval;
      12'hF14: old_val = 32'b0;
`ifdef CPU6_CSR_COUNTERS_EN
      12'hB00: old_val = mcycle[31:0];
      12'hB80: old_val = mcycle[63:32];
      12'hB02: old_val = minstret[31:0];
      12'hB82: old_val = minstret[63:32];
`endif
      default: impl = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec_q  <= RESET_MTVEC[31:2];
      mepc_q   <= 30'b0;
      mscratch <= 32'b0;
      mcause   <= 32'b0;
      mtval    <= 32'b0;
    end else if (exc_valid) begin
      mepc_q <= exc_pc[31:2];
      mcause <= 32'd2;
      mtval  <= exc_instr;
      mpie   <= mie;
      mie    <= 1'b0;
    end else begin
      if (mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (we && csr_addr == 12'h300) begin
        mie  <= new_val[3];
        mpie <= new_val[7];
      end
      if (we && csr_addr == 12'h305) mtvec_q <= new_val[31:2];
      if (we && csr_addr == 12'h340) mscratch <= new_val;
      if (we && csr_addr == 12'h341) mepc_q <= new_val[31:2];
      if (we && csr_addr == 12'h342) mcause <= new_val;
      if (we && csr_addr == 12'h343) mtval <= new_val;
    end
  end
`ifdef CPU6_CSR_COUNTERS_EN
  // an explicit write to either half freezes the whole counter for that cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcycle   <= 64'b0;
      minstret <= 64'b0;
    end else begin
      if (we && csr_addr == 12'hB00) mcycle[31:0] <= new_val;
      else if (we && csr_addr == 12'hB80) mcycle[63:32] <= new_val;
      else mcycle <= mcycle + 64'd1;
      if (we && csr_addr == 12'hB02) minstret[31:0] <= new_val;
      else if (we && csr_addr == 12'hB82) minstret[63:32] <= new_val;
      else minstret <= minstret + {63'b0, instr_retire};
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif
endmodule

// File: tb/tb_cpu6_csrfile.sv
// tb_cpu6_csrfile: directed self-checking bench for cpu6_csrfile.
module tb_cpu6_csrfile;
  localparam logic [1:0] W = 2'b01, S = 2'b10, C = 2'b11;
  localparam logic [31:0] RMTVEC = 32'h0000_0400;
  logic clk = 1'b0, resetn = 1'b0;
  logic csr_en = 1'b0, csr_rs1uimm = 1'b0, exc_valid = 1'b0, mret = 1'b0, instr_retire = 1'b0;
  logic [1:0] csr_wsc = 2'b0;
  logic [4:0] csr_rs1idx = 5'b0;
  logic [11:0] csr_addr = 12'b0;
  logic [31:0] rs1_data = 32'b0, exc_pc = 32'b0, exc_instr = 32'b0;
  logic [31:0] csr_rdata, trap_vec, epc;
  logic csr_illegal;
  int passed = 0, total = 0;
  cpu6_csrfile #(.RESET_MTVEC(RMTVEC), .MISA_VALUE(32'h4000_0100)) dut (
    .clk(clk), .resetn(resetn), .csr_en(csr_en), .csr_wsc(csr_wsc),
    .csr_rs1uimm(csr_rs1uimm), .csr_rs1idx(csr_rs1idx), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_instr(exc_instr), .mret(mret),
    .instr_retire(instr_retire), .trap_vec(trap_vec), .epc(epc));
  always #5 clk = ~clk;
  task automatic op(input logic en, input logic [1:0] wsc, input logic ui,
                    input logic [4:0] idx, input logic [11:0] a, input logic [31:0] d);
    csr_en = en; csr_wsc = wsc; csr_rs1uimm = ui; csr_rs1idx = idx; csr_addr = a; rs1_data = d;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    op(1'b1, S, 1'b0, 5'd0, a, 32'hFFFF_FFFF);
    #1 chk(tag, csr_rdata, exp);
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  initial begin
    #12 resetn = 1'b1;
    step;
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    chk("rst_illegal", {31'b0, csr_illegal}, 32'd0);
    rd("rst_mtvec", 12'h305, RMTVEC);
    chk("rst_trapvec", trap_vec, RMTVEC);
    op(1'b1, W, 1'b0, 5'd5, 12'h340, 32'hDEAD_BEEF);
    #1 chk("csrrw_old", csr_rdata, 32'd0);
    step;
    rd("csrrs_read", 12'h340, 32'hDEAD_BEEF);
    step;
    rd("csrrs_nowrite", 12'h340, 32'hDEAD_BEEF);
    op(1'b1, C, 1'b1, 5'h0F, 12'h340, 32'hFFFF_FFFF);
    #1 chk("csrrci_old", csr_rdata, 32'hDEAD_BEEF);
    step;
    rd("csrrci_new", 12'h340, 32'hDEAD_BEE0);
    op(1'b1, S, 1'b0, 5'd0, 12'h7C0, 32'd0);
    #1 chk("unimpl_ill", {31'b0, csr_illegal}, 32'd1);
    chk("unimpl_rdata", csr_rdata, 32'd0);
    op(1'b1, W, 1'b0, 5'd1, 12'hF14, 32'h1234_5678);
    #1 chk("hartid_w_ill", {31'b0, csr_illegal}, 32'd1);
    step;
    rd("hartid_read", 12'hF14, 32'd0);
    chk("hartid_s0_ill", {31'b0, csr_illegal}, 32'd0);
    op(1'b1, W, 1'b0, 5'd1, 12'h301, 32'h0);
    #1 chk("misa_w_legal", {31'b0, csr_illegal}, 32'd0);
    chk("misa_val", csr_rdata, 32'h4000_0100);
    step;
    rd("misa_kept", 12'h301, 32'h4000_0100);
    op(1'b1, W, 1'b0, 5'd1, 12'h341, 32'h0000_0123);
    step;
    rd("mepc_align", 12'h341, 32'h0000_0120);
    op(1'b1, S, 1'b1, 5'd8, 12'h300, 32'd0);
    step;
    rd("mie_set", 12'h300, 32'h0000_1808);
    exc_valid = 1'b1; exc_pc = 32'h100; exc_instr = 32'hFFFF_FFFF;
    op(1'b1, W, 1'b0, 5'd1, 12'h340, 32'h5555_5555);
    step;
    exc_valid = 1'b0;
    rd("trap_mepc", 12'h341, 32'h100);
    rd("trap_mcause", 12'h342, 32'd2);
    rd("trap_mtval", 12'h343, 32'hFFFF_FFFF);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mscratch", 12'h340, 32'hDEAD_BEE0);
    chk("trap_epc", epc, 32'h100);
    op(1'b1, W, 1'b0, 5'd1, 12'h300, 32'h0);
    mret = 1'b1;
    step;
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_epc", epc, 32'h100);
`ifdef CPU6_CSR_COUNTERS_EN
    op(1'b1, W, 1'b0, 5'd1, 12'hB00, 32'hFFFF_FFFF);
    step;
    op(1'b1, W, 1'b0, 5'd1, 12'hB80, 32'h0);
    step;
    rd("mcycle_lo_hold", 12'hB00, 32'hFFFF_FFFF);
    step;
    rd("mcycleh_carry", 12'hB80, 32'd1);
    rd("mcycle_wrap", 12'hB00, 32'd0);
    rd("minstret_zero", 12'hB02, 32'd0);
    for (int i = 0; i < 5; i++) begin
      instr_retire = (i != 1 && i != 4);
      step;
    end
    instr_retire = 1'b0;
    rd("minstret_cnt", 12'hB02, 32'd3);
    rd("minstreth", 12'hB82, 32'd0);
`else
    op(1'b1, S, 1'b0, 5'd0, 12'hB00, 32'd0);
    #1 chk("mcycle_ill", {31'b0, csr_illegal}, 32'd1);
    op(1'b1, S, 1'b0, 5'd0, 12'hB82, 32'd0);
    #1 chk("minstreth_ill", {31'b0, csr_illegal}, 32'd1);
`endif
    op(1'b1, W, 1'b0, 5'd1, 12'h305, 32'h200);
    step;
    rd("mtvec_written", 12'h305, 32'h200);
    op(1'b1, W, 1'b0, 5'd1, 12'h305, 32'h300);
    #2 resetn = 1'b0;
    op(1'b0, 2'b0, 1'b0, 5'd0, 12'h0, 32'd0);
    #2 resetn = 1'b1;
    step;
    rd("rst_mid_mtvec", 12'h305, RMTVEC);
    rd("rst_mid_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mid_mscratch", 12'h340, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
